// File: rtl/u_rec_pkt_ctrl_if.sv
// Payload delivery stream between the packet controller and its consumer.
//   out_dataH  : payload byte
//   out_validH : out_dataH valid
//   out_readyH : consumer accepts the byte
//   out_lastH  : final payload byte of the packet (qualified by out_validH)
//   pkt_lenH   : payload length of the packet being delivered
// master = packet controller, slave = consumer.
interface u_rec_pkt_ctrl_if;
  logic [7:0] out_dataH;
  logic       out_validH;
  logic       out_readyH;
  logic       out_lastH;
  logic [4:0] pkt_lenH;

  modport master (
    output out_dataH, out_validH, out_lastH, pkt_lenH,
    input  out_readyH
  );

  modport slave (
    input  out_dataH, out_validH, out_lastH, pkt_lenH,
    output out_readyH
  );
endinterface

// File: rtl/u_rec_pkt_ctrl.sv
// Packet controller behind the UART receiver. It turns receiver byte
// completions into framed packets (SYNC, LEN, payload, checksum), buffers
// the payload and hands good packets to a single consumer over a
// valid/ready byte stream. Error conditions are single-cycle pulses.
//
// Ports:
//   sys_clk, sys_rst_l : clock, asynchronous active-low reset
//   rec_dataH          : receiver parallel byte
//   rec_readyH         : receiver ready level (low while receiving)
//   out_if             : payload stream (master side)
//   err_chksumH        : checksum mismatch pulse
//   err_lenH           : LEN of 0 or above MAX_LEN pulse
//   err_timeoutH       : inter-byte timeout pulse
//   ovr_dropH          : byte discarded while delivering pulse
//
// state   | meaning
// --------+----------------------------------------------------
// HUNT    | waiting for SYNC_BYTE
// LEN     | waiting for the length byte
// PAYLOAD | storing payload bytes, accumulating checksum
// CHKSUM  | waiting for the checksum byte
// DELIVER | streaming buffered payload to the consumer
module u_rec_pkt_ctrl #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         MIN_LOW_CYC = 100,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_l,
  input  logic [7:0]             rec_dataH,
  input  logic                   rec_readyH,
  u_rec_pkt_ctrl_if.master       out_if,
  output logic                   err_chksumH,
  output logic                   err_lenH,
  output logic                   err_timeoutH,
  output logic                   ovr_dropH
);

  localparam int          AW        = $clog2(MAX_LEN);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [7:0]  MIN_LOW_B = 8'(MIN_LOW_CYC);
  localparam logic [15:0] TMO_LOAD  = 16'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHKSUM  = 3'd3,
    DELIVER = 3'd4
  } state_t;

  state_t      state, state_nxt;

  logic        ready_dH;
  logic [7:0]  low_cntH;
  logic        byte_stbH;

  logic [4:0]  len;
  logic [7:0]  chk;
  logic [4:0]  idx;
  logic [4:0]  rd_idx;
  logic [7:0]  pl_buf [MAX_LEN];

  logic [15:0] tmo_cnt;
  logic        tmo_active;
  logic        tmo_hit;

  logic        deliver;
  logic        last_byte;
  logic        xfer;

  logic        err_chk_nxt, err_len_nxt, err_tmo_nxt, ovr_nxt;

  // Byte strobe: a rising edge of rec_readyH counts only after a long enough
  // low period, which filters receiver false starts and the reset release.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      ready_dH <= 1'b0;
      low_cntH <= '0;
    end else begin
      ready_dH <= rec_readyH;
      if (rec_readyH)
        low_cntH <= '0;
      else if (low_cntH < MIN_LOW_B)
        low_cntH <= low_cntH + 8'd1;
    end
  end

  assign byte_stbH = rec_readyH & ~ready_dH & (low_cntH >= MIN_LOW_B);

  // Stream outputs are decoded from the registered state, so reset clears
  // them immediately.
  assign deliver   = (state == DELIVER);
  assign last_byte = (rd_idx == len - 5'd1);
  assign xfer      = deliver & out_if.out_readyH;

  assign out_if.out_validH = deliver;
  assign out_if.out_dataH  = deliver ? pl_buf[rd_idx[AW-1:0]] : 8'h00;
  assign out_if.out_lastH  = deliver & last_byte;
  assign out_if.pkt_lenH   = deliver ? len : 5'd0;

  // Inter-byte timer: down-counter reloaded outside the framing states and
  // on every strobe; a strobe in the terminal-count cycle suppresses the hit.
  assign tmo_active = (state == LEN) || (state == PAYLOAD) || (state == CHKSUM);
  assign tmo_hit    = tmo_active && (tmo_cnt == 16'd0) && !byte_stbH;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l)
      tmo_cnt <= '0;
    else if (!tmo_active || byte_stbH)
      tmo_cnt <= TMO_LOAD;
    else if (tmo_cnt != 16'd0)
      tmo_cnt <= tmo_cnt - 16'd1;
  end

  always_comb begin
    state_nxt   = state;
    err_chk_nxt = 1'b0;
    err_len_nxt = 1'b0;
    err_tmo_nxt = 1'b0;
    ovr_nxt     = 1'b0;
    case (state)
      HUNT: begin
        if (byte_stbH && rec_dataH == SYNC_BYTE)
          state_nxt = LEN;
      end
      LEN: begin
        if (byte_stbH) begin
          if (rec_dataH != 8'd0 && rec_dataH <= MAX_LEN_B) begin
            state_nxt = PAYLOAD;
          end else begin
            err_len_nxt = 1'b1;
            state_nxt   = HUNT;
          end
        end
      end
      PAYLOAD: begin
        if (byte_stbH && (idx + 5'd1 == len))
          state_nxt = CHKSUM;
      end
      CHKSUM: begin
        if (byte_stbH) begin
          if (rec_dataH == chk) begin
            state_nxt = DELIVER;
          end else begin
            err_chk_nxt = 1'b1;
            state_nxt   = HUNT;
          end
        end
      end
      DELIVER: begin
        // Bytes arriving while delivering are dropped, SYNC included.
        if (byte_stbH)
          ovr_nxt = 1'b1;
        if (xfer && last_byte)
          state_nxt = HUNT;
      end
      default: state_nxt = HUNT;
    endcase
    if (tmo_hit) begin
      err_tmo_nxt = 1'b1;
      state_nxt   = HUNT;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state        <= HUNT;
      err_chksumH  <= 1'b0;
      err_lenH     <= 1'b0;
      err_timeoutH <= 1'b0;
      ovr_dropH    <= 1'b0;
    end else begin
      state        <= state_nxt;
      err_chksumH  <= err_chk_nxt;
      err_lenH     <= err_len_nxt;
      err_timeoutH <= err_tmo_nxt;
      ovr_dropH    <= ovr_nxt;
    end
  end

  // Frame bookkeeping: length, running checksum, write and read indices.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      len    <= '0;
      chk    <= '0;
      idx    <= '0;
      rd_idx <= '0;
    end else begin
      case (state)
        LEN: begin
          if (byte_stbH && rec_dataH != 8'd0 && rec_dataH <= MAX_LEN_B) begin
            len <= rec_dataH[4:0];
            chk <= rec_dataH;
            idx <= '0;
          end
        end
        PAYLOAD: begin
          if (byte_stbH) begin
            chk <= chk + rec_dataH;
            idx <= idx + 5'd1;
          end
        end
        default: ;
      endcase
      if (!deliver)
        rd_idx <= '0;
      else if (xfer)
        rd_idx <= rd_idx + 5'd1;
    end
  end

  // Payload storage needs no reset: it is only read while delivering.
  always_ff @(posedge sys_clk) begin
    if (state == PAYLOAD && byte_stbH)
      pl_buf[idx[AW-1:0]] <= rec_dataH;
  end

endmodule
